// File: rtl/div_ctrl.sv
// Sequencing controller in front of the iterative divider: resolves div-by-zero, signed overflow and repeat operands
// locally (1-cycle result), else issues to the divider; stalls the pipeline until writeback, flush or timeout.
module div_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_rs1,
  input  logic [DW-1:0] req_rs2,
  input  logic [4:0]    req_rd,
  input  logic          flush_i,
  output logic [DW-1:0] div_dividend,
  output logic [DW-1:0] div_divisor,
  output logic          div_signed,
  output logic          div_en,
  input  logic [DW-1:0] div_quot,
  input  logic [DW-1:0] div_rem,
  input  logic          div_done,
  input  logic          div_busy,
  output logic          stall_o,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          err_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] SMIN    = {1'b1, {(DW-1){1'b0}}};

  state_t        state;
  logic [CW-1:0] cnt;
  logic          want_rem;
  logic          cache_valid;
  logic          cache_signed;
  logic [DW-1:0] cache_rs1, cache_rs2, cache_quot, cache_rem;

  logic req_signed, div_zero, ovf, hit, accept;

  assign req_signed = ~req_op[0];
  assign div_zero   = (req_rs2 == '0);
  assign ovf        = req_signed && (req_rs1 == SMIN) && (req_rs2 == '1);
  assign hit        = cache_valid && (cache_rs1 == req_rs1) && (cache_rs2 == req_rs2) &&
                      (cache_signed == req_signed);
  assign accept     = (state == IDLE) && req_valid && !flush_i;

  assign stall_o  = accept || (state == ISSUE) || (state == WAIT) || (state == DRAIN);
  // A flush landing in the writeback cycle must still be able to kill the strobe.
  assign wb_valid = (state == DONE) && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      want_rem     <= 1'b0;
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_quot   <= '0;
      cache_rem    <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_signed   <= 1'b0;
      div_en       <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      err_o        <= 1'b0;
    end else begin
      div_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            want_rem <= req_op[1];
            wb_rd    <= req_rd;
            if (div_zero) begin
              wb_data <= req_op[1] ? req_rs1 : '1;
              state   <= DONE;
            end else if (ovf) begin
              wb_data <= req_op[1] ? '0 : req_rs1;
              state   <= DONE;
            end else if (hit) begin
              wb_data <= req_op[1] ? cache_rem : cache_quot;
              state   <= DONE;
            end else begin
              div_dividend <= req_rs1;
              div_divisor  <= req_rs2;
              div_signed   <= req_signed;
              div_en       <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= flush_i ? DRAIN : WAIT;
        end
        WAIT: begin
          if (flush_i) begin
            cnt <= '0;
            // Result already arriving alongside the flush: nothing left to drain.
            if (div_done) begin
              cache_valid <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (div_done) begin
            cache_valid  <= 1'b1;
            cache_rs1    <= div_dividend;
            cache_rs2    <= div_divisor;
            cache_signed <= div_signed;
            cache_quot   <= div_quot;
            cache_rem    <= div_rem;
            wb_data      <= want_rem ? div_rem : div_quot;
            state        <= DONE;
          end else if (cnt == CNT_MAX) begin
            err_o       <= 1'b1;
            cache_valid <= 1'b0;
            wb_data     <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (div_done || (!div_busy && cnt == CNT_MAX)) begin
            cache_valid <= 1'b0;
            state       <= IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider, a per-cycle expectation scoreboard and literal checks.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        flush_i;
  logic [31:0] div_dividend, div_divisor;
  logic        div_signed, div_en;
  logic [31:0] div_quot, div_rem;
  logic        div_done, div_busy;
  logic        stall_o, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_o;

  div_ctrl #(.DW(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush_i(flush_i),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_signed(div_signed),
    .div_en(div_en), .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done),
    .div_busy(div_busy), .stall_o(stall_o), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  bit run_cmp = 1'b0;

  // Expected per-cycle behaviour, filled in by the model when a request is accepted.
  bit          exp_wbv [0:4095];
  logic [31:0] exp_wbd [0:4095];
  logic [4:0]  exp_wbr [0:4095];
  bit          exp_en  [0:4095];

  bit          m_cv = 1'b0;
  logic [31:0] m_a, m_b;
  logic        m_s;

  int dv_delay = 1;
  bit dv_hang  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // RISC-V M-extension division semantics: {quotient, remainder}.
  function automatic logic [63:0] ref_qr(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF; r = a;
    end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = a; r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  task automatic predict(input int c, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int d, input bit hang, input bit flushed);
    logic        s;
    logic [63:0] qr;
    logic [31:0] res;
    bit          special, hit;
    int          w;
    s       = ~op[0];
    qr      = ref_qr(s, a, b);
    res     = op[1] ? qr[31:0] : qr[63:32];
    special = (b == 32'd0) || (s && a == 32'h80000000 && b == 32'hFFFFFFFF);
    hit     = m_cv && m_a == a && m_b == b && m_s == s;
    if (special || hit) begin
      exp_wbv[c+1] = 1'b1; exp_wbd[c+1] = res; exp_wbr[c+1] = rd;
    end else begin
      exp_en[c+1] = 1'b1;
      if (flushed || hang) m_cv = 1'b0;
      else begin m_cv = 1'b1; m_a = a; m_b = b; m_s = s; end
      if (!flushed) begin
        w = c + 2 + (hang ? 64 : d);
        exp_wbv[w] = 1'b1; exp_wbd[w] = hang ? 32'd0 : res; exp_wbr[w] = rd;
      end
    end
  endtask

  // Divider: busy from the cycle after div_en, wd_en pulse d cycles after div_en.
  initial begin
    logic [63:0] qr;
    div_done = 1'b0; div_busy = 1'b0; div_quot = '0; div_rem = '0;
    forever begin
      @(negedge clk);
      if (div_en) begin
        qr = ref_qr(div_signed, div_dividend, div_divisor);
        @(posedge clk); #1;
        div_busy = 1'b1;
        if (!dv_hang) begin
          repeat (dv_delay - 1) @(posedge clk);
          #1;
          div_done = 1'b1; div_quot = qr[63:32]; div_rem = qr[31:0]; div_busy = 1'b0;
          @(posedge clk); #1;
          div_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && run_cmp) begin
      chk("wb_valid", wb_valid, exp_wbv[cyc]);
      if (exp_wbv[cyc]) begin
        chk("wb_data", wb_data, exp_wbd[cyc]);
        chk("wb_rd", wb_rd, exp_wbr[cyc]);
      end
      chk("div_en", div_en, exp_en[cyc]);
      if (div_en) chk("en_while_busy", div_busy, 0);
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int d, input bit hang,
                        output int lat, output logic [31:0] data);
    int c, n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    dv_delay = d; dv_hang = hang;
    c = cyc;
    predict(c, op, a, b, rd, d, hang, 1'b0);
    n = 0;
    @(negedge clk);
    while (stall_o && n < 300) begin @(negedge clk); n++; end
    chk("stall_release", stall_o, 0);
    chk("wb_at_stall_drop", wb_valid, 1);
    lat  = cyc - c;
    data = wb_data;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_div_en"}, div_en, 0);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_dividend"}, div_dividend, 0);
    chk({tag, "_divisor"}, div_divisor, 0);
    chk({tag, "_signed"}, div_signed, 0);
  endtask

  initial begin
    int          lat, fc, n;
    logic [31:0] data;
    logic [63:0] qr;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    rst = 1'b0; run_cmp = 1'b1;

    qr = ref_qr(1'b1, 32'd100, 32'd7);
    chk("model_q_100_7", qr[63:32], 32'd14);
    qr = ref_qr(1'b1, 32'hFFFFFFEC, 32'd3);
    chk("model_r_m20_3", qr[31:0], 32'hFFFFFFFE);

    do_req(2'b00, 32'd100, 32'd7, 5'd3, 34, 1'b0, lat, data);
    chk("div_lat", lat, 36);
    chk("div_data", data, 32'd14);

    do_req(2'b00, 32'hFFFFFFEC, 32'd3, 5'd4, 10, 1'b0, lat, data);
    chk("neg_div_lat", lat, 12);
    chk("neg_div_data", data, 32'hFFFFFFFA);
    do_req(2'b10, 32'hFFFFFFEC, 32'd3, 5'd5, 10, 1'b0, lat, data);
    chk("hit_rem_lat", lat, 1);
    chk("hit_rem_data", data, 32'hFFFFFFFE);

    do_req(2'b01, 32'h1234, 32'd0, 5'd6, 1, 1'b0, lat, data);
    chk("divu0_lat", lat, 1);
    chk("divu0_data", data, 32'hFFFFFFFF);
    do_req(2'b11, 32'h1234, 32'd0, 5'd6, 1, 1'b0, lat, data);
    chk("remu0_data", data, 32'h1234);

    do_req(2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1, 1'b0, lat, data);
    chk("ovf_div_data", data, 32'h80000000);
    do_req(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1, 1'b0, lat, data);
    chk("ovf_rem_lat", lat, 1);
    chk("ovf_rem_data", data, 32'd0);
    go_idle();

    // Flush five cycles after div_en; stall must persist until the divider's wd_en.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd500; req_rs2 = 32'd9; req_rd = 5'd10;
    dv_delay = 34; dv_hang = 1'b0;
    fc = cyc;
    predict(fc, 2'b00, 32'd500, 32'd9, 5'd10, 34, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    flush_i = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (stall_o && n < 300) begin @(negedge clk); n++; end
    chk("flush_stall_end", cyc - fc, 36);
    do_req(2'b00, 32'd500, 32'd9, 5'd10, 4, 1'b0, lat, data);
    chk("reissue_lat", lat, 6);
    chk("reissue_data", data, 32'd55);

    do_req(2'b11, 32'd1000, 32'd7, 5'd11, 5, 1'b0, lat, data);
    chk("remu_lat", lat, 7);
    chk("remu_data", data, 32'd6);

    do_req(2'b00, 32'd77, 32'd5, 5'd12, 1, 1'b1, lat, data);
    chk("timeout_lat", lat, 66);
    chk("timeout_data", data, 32'd0);
    chk("timeout_err", err_o, 1);
    go_idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", err_o, 1);

    @(posedge clk); #1;
    rst = 1'b1; div_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
